// File: rtl/smash_noc_pkg.sv
// smash_noc_pkg: shared definitions for the SMASH network interface.
//   - Default field widths of a header flit.
//   - Header field MSB helpers. src sits at the top of the flit and dst
//     directly below it. The length field occupies [len_size-1:0].
//   - NI receive FSM state encodings.
package smash_noc_pkg;

    localparam int unsigned DEF_DATA_SIZE = 32;
    localparam int unsigned DEF_ID_SIZE   = 4;
    localparam int unsigned HDR_LEN_SIZE  = 8;

    // Receive FSM encodings (2-bit, legacy values)
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PAYLOAD = 2'd1;
    localparam logic [1:0] DROP    = 2'd2;

    function automatic int unsigned src_msb(input int unsigned data_size);
        return data_size - 1;
    endfunction

    function automatic int unsigned dst_msb(input int unsigned data_size,
                                            input int unsigned id_size);
        return data_size - 1 - id_size;
    endfunction

endpackage

// File: rtl/smash_ni_rx_out_reg.sv
// smash_out_reg: one-entry valid/ready output register carrying
// {last, src, data} towards the core.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture in_data/in_last/in_src; valid is set
//   src_upd   : refresh src only (header of a new packet), applied only when
//               the held word is gone or leaves this cycle
//   in_*      : incoming word fields
//   ready     : consumer accepts when valid & ready
//   valid, data, last, src : registered outputs
module smash_out_reg
#(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned ID_SIZE   = 4
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 src_upd,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic                 in_last,
    input  logic [ID_SIZE-1:0]   in_src,
    input  logic                 ready,
    output logic                 valid,
    output logic [DATA_SIZE-1:0] data,
    output logic                 last,
    output logic [ID_SIZE-1:0]   src
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
            src   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= in_data;
            last  <= in_last;
            src   <= in_src;
        end else begin
            if (ready)
                valid <= 1'b0;
            // src must not change under a word still waiting for ready
            if (src_upd && (!valid || ready))
                src <= in_src;
        end
    end

endmodule

// File: rtl/smash_ni_rx.sv
// smash_ni_rx: NI receive side. Pops flits from a first-word-fall-through
// FIFO, parses headers, drops foreign packets and streams payload words to
// the local core over valid/ready with an end-of-packet marker.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_fifo_data      : FIFO head flit (valid while i_fifo_empty=0)
//   i_fifo_empty     : FIFO empty flag
//   o_fifo_read      : pop strobe, head consumed at the clock edge
//   o_data/o_last/o_src/o_valid, i_ready : payload stream to the core
//   o_drop           : 1-cycle pulse after a foreign-dst header pop
//   o_err            : 1-cycle pulse after a zero-length header pop
module smash_ni_rx
    import smash_noc_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
    parameter int unsigned ID_SIZE   = DEF_ID_SIZE,
    parameter int unsigned LEN_SIZE  = HDR_LEN_SIZE,
    parameter int unsigned NODE_ID   = 0
)
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DATA_SIZE-1:0] i_fifo_data,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_read,
    output logic [DATA_SIZE-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_last,
    output logic [ID_SIZE-1:0]   o_src,
    output logic                 o_drop,
    output logic                 o_err
);

    localparam int unsigned        SRC_MSB = src_msb(DATA_SIZE);
    localparam int unsigned        DST_MSB = dst_msb(DATA_SIZE, ID_SIZE);
    localparam logic [ID_SIZE-1:0] MY_ID   = ID_SIZE'(NODE_ID);

    logic [1:0]          state;
    logic [LEN_SIZE-1:0] cnt;
    logic [ID_SIZE-1:0]  cur_src;

    logic [ID_SIZE-1:0]  hdr_src;
    logic [ID_SIZE-1:0]  hdr_dst;
    logic [LEN_SIZE-1:0] hdr_len;
    logic                pop;
    logic                hdr_pop;
    logic                len_zero;
    logic                foreign;
    logic                load;
    logic                src_upd;
    logic                last_flit;
    logic [ID_SIZE-1:0]  reg_src_in;

    assign hdr_src = i_fifo_data[SRC_MSB -: ID_SIZE];
    assign hdr_dst = i_fifo_data[DST_MSB -: ID_SIZE];
    assign hdr_len = i_fifo_data[LEN_SIZE-1:0];

    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = !i_fifo_empty;
            PAYLOAD: pop = !i_fifo_empty && (!o_valid || i_ready);
            DROP:    pop = !i_fifo_empty;
            default: pop = 1'b0;
        endcase
        // FIFO is reset alongside; never consume a flit during reset
        if (i_rst)
            pop = 1'b0;
    end

    assign o_fifo_read = pop;
    assign hdr_pop     = pop && (state == IDLE);
    assign len_zero    = (hdr_len == '0);
    assign foreign     = (hdr_dst != MY_ID);
    assign load        = pop && (state == PAYLOAD);
    assign src_upd     = hdr_pop && !len_zero && !foreign;
    assign last_flit   = (cnt == LEN_SIZE'(1));
    // header pops offer the fresh src; payload loads carry the latched one
    assign reg_src_in  = (state == IDLE) ? hdr_src : cur_src;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_src <= '0;
            o_drop  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_drop <= hdr_pop && !len_zero && foreign;
            o_err  <= hdr_pop && len_zero;
            case (state)
                IDLE: begin
                    if (hdr_pop && !len_zero) begin
                        cnt <= hdr_len;
                        if (foreign) begin
                            state <= DROP;
                        end else begin
                            state   <= PAYLOAD;
                            cur_src <= hdr_src;
                        end
                    end
                end
                PAYLOAD, DROP: begin
                    if (pop) begin
                        cnt <= cnt - LEN_SIZE'(1);
                        if (last_flit)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    smash_out_reg #(
        .DATA_SIZE(DATA_SIZE),
        .ID_SIZE  (ID_SIZE)
    ) u_out_reg (
        .clk    (i_clk),
        .rst    (i_rst),
        .load   (load),
        .src_upd(src_upd),
        .in_data(i_fifo_data),
        .in_last(last_flit),
        .in_src (reg_src_in),
        .ready  (i_ready),
        .valid  (o_valid),
        .data   (o_data),
        .last   (o_last),
        .src    (o_src)
    );

endmodule
